// File: rtl/alu_branch_dmem_pkg.sv
// Shared encodings for the ALU / branch / data-memory slice: ALU opcodes,
// branch funct3, instruction opcodes and load/store access masks.
package alu_branch_dmem_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] MASK_B  = 3'b000;
  localparam logic [2:0] MASK_H  = 3'b001;
  localparam logic [2:0] MASK_W  = 3'b010;
  localparam logic [2:0] MASK_BU = 3'b100;
  localparam logic [2:0] MASK_HU = 3'b101;

endpackage

// File: rtl/data_ram.sv
// Byte-addressed little-endian data memory with wrapping multi-byte access.
// Optional macro DMEM_CLEAR_ON_RST_EN zeroes every byte on each reset edge.
module data_ram
  import alu_branch_dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic        mem_wr,
  input  logic        mem_rd,
  input  logic [2:0]  mask,
  output logic [31:0] dmem_o
);

  localparam int AW = $clog2(DEPTH_BYTES);

  logic [7:0]    mem [DEPTH_BYTES];
  logic [AW-1:0] a0, a1, a2, a3;
  logic [7:0]    r0, r1, r2, r3;
  logic          unused_addr;

  // Byte indices are truncated to AW bits so a multi-byte access wraps to 0.
  assign a0 = addr[AW-1:0];
  assign a1 = a0 + AW'(1);
  assign a2 = a0 + AW'(2);
  assign a3 = a0 + AW'(3);
  assign unused_addr = ^addr[31:AW];

  assign r0 = mem[a0];
  assign r1 = mem[a1];
  assign r2 = mem[a2];
  assign r3 = mem[a3];

  function automatic logic [31:0] sext8(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_ON_RST_EN
    if (rst) begin
      for (int i = 0; i < DEPTH_BYTES; i++) mem[i] <= '0;
    end else
`endif
    if (!rst && mem_wr) begin
      case (mask)
        MASK_B: mem[a0] <= wr_data[7:0];
        MASK_H: begin
          mem[a0] <= wr_data[7:0];
          mem[a1] <= wr_data[15:8];
        end
        MASK_W: begin
          mem[a0] <= wr_data[7:0];
          mem[a1] <= wr_data[15:8];
          mem[a2] <= wr_data[23:16];
          mem[a3] <= wr_data[31:24];
        end
        default: ;
      endcase
    end
  end

  // Reads see the array before the edge, so read-during-write returns old data.
  always_comb begin
    dmem_o = '0;
    if (!rst && mem_rd) begin
      case (mask)
        MASK_B:  dmem_o = sext8(r0);
        MASK_H:  dmem_o = sext16({r1, r0});
        MASK_W:  dmem_o = {r3, r2, r1, r0};
        MASK_BU: dmem_o = {24'b0, r0};
        MASK_HU: dmem_o = {16'b0, r1, r0};
        default: dmem_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_branch_dmem.sv
// Combinational ALU and branch-decision logic plus the data memory.
// Build option: DMEM_CLEAR_ON_RST_EN (memory cleared while rst is high).
module alu_branch_dmem
  import alu_branch_dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  alu_op,
  output logic [31:0] alu_o,
  input  logic [2:0]  br_type,
  input  logic [6:0]  op_code,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        br_en,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic        mem_wr,
  input  logic        mem_rd,
  input  logic [2:0]  mask,
  output logic [31:0] dmem_o
);

  logic signed [31:0] a_s, rs1_s, rs2_s;
  logic        [4:0]  shamt;

  assign a_s   = a;
  assign rs1_s = rs1_data;
  assign rs2_s = rs2_data;
  assign shamt = b[4:0];

  always_comb begin
    alu_o = '0;
    case (alu_op)
      ALU_ADD:    alu_o = a + b;
      ALU_SUB:    alu_o = a - b;
      ALU_SLL:    alu_o = a << shamt;
      ALU_SLT:    alu_o = {31'b0, a_s < $signed(b)};
      ALU_SLTU:   alu_o = {31'b0, a < b};
      ALU_XOR:    alu_o = a ^ b;
      ALU_SRL:    alu_o = a >> shamt;
      ALU_SRA:    alu_o = a_s >>> shamt;
      ALU_OR:     alu_o = a | b;
      ALU_AND:    alu_o = a & b;
      ALU_PASS_B: alu_o = b;
      default:    alu_o = '0;
    endcase
  end

  always_comb begin
    br_en = 1'b0;
    case (op_code)
      OP_JAL, OP_JALR: br_en = 1'b1;
      OP_BRANCH: begin
        case (br_type)
          BR_EQ:   br_en = (rs1_data == rs2_data);
          BR_NE:   br_en = (rs1_data != rs2_data);
          BR_LT:   br_en = (rs1_s < rs2_s);
          BR_GE:   br_en = (rs1_s >= rs2_s);
          BR_LTU:  br_en = (rs1_data < rs2_data);
          BR_GEU:  br_en = (rs1_data >= rs2_data);
          default: br_en = 1'b0;
        endcase
      end
      default: br_en = 1'b0;
    endcase
  end

  data_ram #(
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_data_ram (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .wr_data(wr_data),
    .mem_wr (mem_wr),
    .mem_rd (mem_rd),
    .mask   (mask),
    .dmem_o (dmem_o)
  );

endmodule

// File: tb/tb_alu_branch_dmem.sv
// Directed scoreboard bench for alu_branch_dmem (default and
// DMEM_CLEAR_ON_RST_EN builds).
module tb_alu_branch_dmem;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b, rs1_data, rs2_data, addr, wr_data;
  logic [3:0]  alu_op;
  logic [2:0]  br_type, mask;
  logic [6:0]  op_code;
  logic        mem_wr, mem_rd;
  logic [31:0] alu_o, dmem_o;
  logic        br_en;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
    logic [31:0] msk;
  } sb_t;

  sb_t sb_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  alu_branch_dmem #(.DEPTH_BYTES(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a(a), .b(b), .alu_op(alu_op), .alu_o(alu_o),
    .br_type(br_type), .op_code(op_code), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .br_en(br_en),
    .addr(addr), .wr_data(wr_data), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mask(mask), .dmem_o(dmem_o)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input int sel, input logic [31:0] exp,
                      input logic [31:0] msk = 32'hFFFF_FFFF);
    sb_t e;
    e.tag = tag; e.sel = sel; e.exp = exp; e.msk = msk;
    sb_q.push_back(e);
  endtask

  task automatic check_all();
    sb_t e;
    logic [31:0] obs;
    @(negedge clk);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        0:       obs = alu_o;
        1:       obs = {31'b0, br_en};
        default: obs = dmem_o;
      endcase
      obs = obs & e.msk;
      n_vec++;
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic alu_chk(input string tag, input logic [3:0] op, input logic [31:0] exp);
    alu_op = op;
    push(tag, 0, exp);
    check_all();
  endtask

  task automatic br_chk(input string tag, input logic [6:0] opc, input logic [2:0] bt,
                        input logic exp);
    op_code = opc; br_type = bt;
    push(tag, 1, {31'b0, exp});
    check_all();
  endtask

  task automatic store(input logic [31:0] ad, input logic [31:0] d, input logic [2:0] m);
    addr = ad; wr_data = d; mask = m; mem_wr = 1'b1;
    @(posedge clk); #1;
    mem_wr = 1'b0;
  endtask

  task automatic load(input string tag, input logic [31:0] ad, input logic [2:0] m,
                      input logic [31:0] exp, input logic [31:0] msk = 32'hFFFF_FFFF);
    addr = ad; mask = m; mem_rd = 1'b1;
    push(tag, 2, exp, msk);
    check_all();
    mem_rd = 1'b0;
  endtask

  initial begin
    rst = 1'b1; a = '0; b = '0; alu_op = '0; br_type = '0; op_code = '0;
    rs1_data = '0; rs2_data = '0; addr = '0; wr_data = '0; mask = 3'b010;
    mem_wr = 1'b0; mem_rd = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push("rst_dmem", 2, 32'h0);
    check_all();
    rst = 1'b0; mem_rd = 1'b0;
    @(posedge clk); #1;

    // ALU pattern 1
    a = 32'h8000_0000; b = 32'h1;
    alu_chk("add", 4'd0, 32'h8000_0001);
    alu_chk("sub", 4'd1, 32'h7FFF_FFFF);
    alu_chk("sll", 4'd2, 32'h0);
    alu_chk("slt", 4'd3, 32'h1);
    alu_chk("sltu", 4'd4, 32'h0);
    alu_chk("xor", 4'd5, 32'h8000_0001);
    alu_chk("srl", 4'd6, 32'h4000_0000);
    alu_chk("sra", 4'd7, 32'hC000_0000);
    alu_chk("or", 4'd8, 32'h8000_0001);
    alu_chk("and", 4'd9, 32'h0);
    alu_chk("passb", 4'd10, 32'h1);
    alu_chk("op11", 4'd11, 32'h0);
    alu_chk("op15", 4'd15, 32'h0);
    // ALU pattern 2: shift amount from b[4:0] only
    a = 32'h0000_00F0; b = 32'hFFFF_FF24;
    alu_chk("add2", 4'd0, 32'h0000_0014);
    alu_chk("slt2", 4'd3, 32'h0);
    alu_chk("sltu2", 4'd4, 32'h1);
    alu_chk("sll2", 4'd2, 32'h0000_0F00);
    alu_chk("sra2", 4'd7, 32'h0000_000F);
    alu_chk("and2", 4'd9, 32'h0000_0020);
    alu_chk("xor2", 4'd5, 32'hFFFF_FFD4);
    a = 32'hFFFF_FFFF; b = 32'd31;
    alu_chk("srl31", 4'd6, 32'h1);
    alu_chk("sra31", 4'd7, 32'hFFFF_FFFF);

    // Branch
    rs1_data = 32'hFFFF_FFFF; rs2_data = 32'h1;
    br_chk("blt", 7'b1100011, 3'b100, 1'b1);
    br_chk("bge", 7'b1100011, 3'b101, 1'b0);
    br_chk("bltu", 7'b1100011, 3'b110, 1'b0);
    br_chk("bgeu", 7'b1100011, 3'b111, 1'b1);
    br_chk("beq", 7'b1100011, 3'b000, 1'b0);
    br_chk("bne", 7'b1100011, 3'b001, 1'b1);
    br_chk("b010", 7'b1100011, 3'b010, 1'b0);
    br_chk("b011", 7'b1100011, 3'b011, 1'b0);
    br_chk("jal", 7'b1101111, 3'b110, 1'b1);
    br_chk("jalr", 7'b1100111, 3'b000, 1'b1);
    br_chk("rtype", 7'b0110011, 3'b100, 1'b0);
    rs1_data = 32'd5; rs2_data = 32'd5;
    br_chk("beq_eq", 7'b1100011, 3'b000, 1'b1);
    br_chk("bge_eq", 7'b1100011, 3'b101, 1'b1);
    br_chk("bltu_eq", 7'b1100011, 3'b110, 1'b0);

    // Store / load
    store(32'd8, 32'h1234_80FF, 3'b010);
    load("lb8", 32'd8, 3'b000, 32'hFFFF_FFFF);
    load("lbu8", 32'd8, 3'b100, 32'h0000_00FF);
    load("lh9", 32'd9, 3'b001, 32'h0000_3480);
    load("lhu10", 32'd10, 3'b101, 32'h0000_1234);
    load("lw8", 32'd8, 3'b010, 32'h1234_80FF);
    load("lh8", 32'd8, 3'b001, 32'hFFFF_80FF);
    load("lb9", 32'd9, 3'b000, 32'hFFFF_FF80);
    store(32'd12, 32'h0000_00AB, 3'b000);
    load("lw9_mis", 32'd9, 3'b010, 32'hAB12_3480);
    store(32'd13, 32'hFFFF_BEEF, 3'b001);
    load("lhu13", 32'd13, 3'b101, 32'h0000_BEEF);
    load("lbu12", 32'd12, 3'b100, 32'h0000_00AB);
    store(32'd8, 32'h0, 3'b011);
    load("nowr_m011", 32'd8, 3'b010, 32'h1234_80FF);
    load("rd_m011", 32'd8, 3'b011, 32'h0);
    load("rd_m110", 32'd8, 3'b110, 32'h0);
    addr = 32'd8; mask = 3'b010; mem_rd = 1'b0;
    push("rd_off", 2, 32'h0);
    check_all();

    // Wrap past the top of memory
    store(DEPTH - 2, 32'hAABB_CCDD, 3'b010);
    load("wrap_lw0", 32'd0, 3'b010, 32'h0000_AABB, 32'h0000_FFFF);
    load("wrap_lhu", DEPTH - 2, 3'b101, 32'h0000_CCDD);
    load("wrap_lw", DEPTH - 2, 3'b010, 32'hAABB_CCDD);

    // Read during write returns old data, new data after the edge
    store(32'd4, 32'h0, 3'b010);
    addr = 32'd4; wr_data = 32'd5; mask = 3'b010; mem_rd = 1'b1; mem_wr = 1'b1;
    push("rdw_before", 2, 32'h0);
    check_all();
    @(posedge clk); #1;
    mem_wr = 1'b0;
    push("rdw_after", 2, 32'h5);
    check_all();
    mem_rd = 1'b0;

    // Reset: writes inhibited, dmem_o forced to 0, ALU unaffected
    store(32'd0, 32'h1122_3344, 3'b010);
    rst = 1'b1; addr = 32'd0; wr_data = 32'd7; mask = 3'b010;
    mem_wr = 1'b1; mem_rd = 1'b1;
    a = 32'd3; b = 32'd4; alu_op = 4'd0;
    op_code = 7'b1101111;
    push("rst_rd0", 2, 32'h0);
    push("rst_alu", 0, 32'd7);
    push("rst_br", 1, 32'h1);
    check_all();
    @(posedge clk); #1;
    push("rst_rd1", 2, 32'h0);
    check_all();
    @(posedge clk); #1;
    // Write presented as reset drops completes on the following edge
    rst = 1'b0; addr = 32'h20; wr_data = 32'h0000_0009;
    @(posedge clk); #1;
    mem_wr = 1'b0;
    load("post_rst_wr", 32'h20, 3'b010, 32'h0000_0009);
`ifdef DMEM_CLEAR_ON_RST_EN
    load("rst_w0", 32'd0, 3'b010, 32'h0);
    load("rst_w8", 32'd8, 3'b010, 32'h0);
`else
    load("rst_w0", 32'd0, 3'b010, 32'h1122_3344);
    load("rst_w8", 32'd8, 3'b010, 32'h1234_80FF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_branch_dmem.md
ALU_BRANCH_DMEM -- requirements
Module: alu_branch_dmem

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 1024 (power of two), data memory size in bytes.
REQ-002 SHALL have one clock and a synchronous, active-high reset:
- clk  in  1  rising-edge clock, sole clock
- rst  in  1  synchronous active-high reset
REQ-003 SHALL have these ALU ports:
- a  in  32  operand A
- b  in  32  operand B
- alu_op  in  4  operation select
- alu_o  out  32  result
REQ-004 SHALL have these branch ports:
- br_type  in  3  branch funct3
- op_code  in  7  instruction opcode
- rs1_data  in  32  compare operand 1
- rs2_data  in  32  compare operand 2
- br_en  out  1  take branch or jump
REQ-005 SHALL have these memory ports:
- addr  in  32  byte address
- wr_data  in  32  store data
- mem_wr  in  1  write enable
- mem_rd  in  1  read enable
- mask  in  3  access funct3
- dmem_o  out  32  load result

Function
REQ-006 SHALL compute alu_o combinationally (0 cycles) as follows; shifts use b[4:0]:
- 0 ADD a+b (mod 2^32)
- 1 SUB a-b
- 2 SLL
- 3 SLT signed (result 1/0)
- 4 SLTU
- 5 XOR
- 6 SRL
- 7 SRA
- 8 OR
- 9 AND
- 10 PASS_B
- 11-15: result 0
REQ-007 SHALL drive br_en combinationally:
- op_code 1101111 (JAL) or 1100111 (JALR): 1.
- op_code 1100011 (BRANCH): br_type 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU; br_type 010 or 011 gives 0.
- Any other op_code: 0.
REQ-008 SHALL store memory as DEPTH_BYTES bytes, little-endian; each byte address is addr modulo DEPTH_BYTES, so a multi-byte access wraps past the top.
REQ-009 SHALL perform writes on the rising clk edge when mem_wr=1 and rst=0:
- mask 000: byte wr_data[7:0].
- mask 001: halfword wr_data[15:0].
- mask 010: word.
- Any other mask: no write.
REQ-010 SHALL read combinationally when mem_rd=1:
- mask 000 LB, sign-extended.
- mask 001 LH, sign-extended.
- mask 010 LW.
- mask 100 LBU, zero-extended.
- mask 101 LHU, zero-extended.
- mask 011/110/111: 0.
- mem_rd=0: dmem_o=0.
REQ-011 SHALL accept misaligned accesses without trapping; bytes are assembled individually per REQ-008.
REQ-012 SHALL make dmem_o return the pre-write contents when mem_rd and mem_wr are both high on the same address; new data is visible after the edge.
REQ-013 SHALL ignore mem_wr when mem_rd=1 only in the sense of REQ-012; reads and writes are independent.

Reset
REQ-014 SHALL inhibit all memory writes while rst=1.
REQ-015 SHALL force dmem_o=0 while rst=1.
REQ-016 SHALL keep alu_o and br_en purely combinational and unaffected by rst.
REQ-017 SHALL complete any write sampled in the cycle rst deasserts on the following edge.

Configuration
REQ-018 SHALL use macro DMEM_CLEAR_ON_RST_EN to control memory clearing on reset:
- Defined: every memory byte is set to 0 on each rising clk edge with rst=1.
- Undefined: memory contents are retained across reset; power-up contents are undefined.

Structure
REQ-019 SHALL place the following in package alu_branch_dmem_pkg:
- alu_op enum
- branch funct3 constants
- opcode constants (BRANCH, JAL, JALR)
- mask constants
REQ-020 SHALL implement the byte storage, write and read assembly in one sub-module named data_ram; ALU and branch logic stay in the top.

Verification
REQ-021 ALU: a=32'h8000_0000, b=1:
- op 0 gives 32'h8000_0001.
- op 3 gives 1.
- op 4 gives 0.
- op 7 gives 32'hC000_0000.
- op 15 gives 0.
REQ-022 Branch: rs1=-1, rs2=1:
- op_code 1100011 br_type 100 gives br_en=1.
- br_type 110 gives 0.
- op_code 1101111 gives 1.
- op_code 0110011 gives 0.
REQ-023 Store/load: SW 32'h1234_80FF at addr 8; then:
- LB @8 gives 32'hFFFF_FFFF.
- LBU @8 gives 32'h0000_00FF.
- LH @9 gives 32'h0000_3480.
- LHU @10 gives 32'h0000_1234.
REQ-024 Wrap: SW 32'hAABBCCDD at addr DEPTH_BYTES-2; then:
- LW @0 gives 32'hxxxxAABB (bytes 0,1 = BB,AA).
- LHU @DEPTH_BYTES-2 gives 32'h0000_CCDD.
REQ-025 Simultaneous: word at 4 = 0, then mem_rd=mem_wr=1, SW 5 at 4 → dmem_o=0 before the edge and 5 after it.
REQ-026 Reset: rst=1 with mem_wr=1 SW 7 at 0, mem_rd=1 → dmem_o=0 and no write occurs. If DMEM_CLEAR_ON_RST_EN is defined, word 8 reads 0 after reset; otherwise it keeps its old value.
